// File: rtl/hazard_sched.sv
// hazard_sched: central stall / flush / forwarding scheduler for the 5-stage
// pipeline. It is the only block that asserts keep/nop on the pipeline
// registers.
//
// Parameters
//   LOAD_LAT     : bubble cycles inserted on a load-use hazard (1..7)
//   FLUSH_CYCLES : squash cycles after a taken branch/jump (1..7)
//
// Ports
//   clk, rst                  : clock, asynchronous active-low reset
//   id_valid, id_rs1, id_rs2  : ID-stage instruction and its source registers
//   id_use_rs1, id_use_rs2    : ID instruction actually reads rs1 / rs2
//   ex_regwrite, ex_memread, ex_rd : EX destination info (load detection)
//   mem_regwrite, mem_rd      : MEM destination info (forwarding)
//   wb_regwrite, wb_rd        : WB destination info (forwarding)
//   br_taken                  : EX resolved a taken branch/jal/jalr
//   dmem_req, dmem_ack        : data-memory handshake seen by MEM
//   pc_keep, if_keep, id_keep, ex_keep : hold the corresponding registers
//   id_nop                    : load a bubble into ID/EX
//   if_flush                  : load a bubble into IF/ID
//   fwd_rs1, fwd_rs2          : 00 regfile, 01 MEM result, 10 WB result
//   busy_state                : current FSM state (debug)
//
// Optional feature (macro HAZARD_SCHED_PERF_EN): adds perf_clr input and the
// saturating perf_stall_cnt / perf_flush_cnt / perf_memwait_cnt outputs.
//
// Handshake: a data access is outstanding while dmem_req=1 and completes in
// the cycle dmem_ack=1; every cycle with dmem_req=1 and dmem_ack=0 is a
// memory-wait cycle that freezes the whole pipeline.
module hazard_sched #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       br_taken,
  input  logic       dmem_req,
  input  logic       dmem_ack,
`ifdef HAZARD_SCHED_PERF_EN
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_memwait_cnt,
`endif
  output logic       pc_keep,
  output logic       if_keep,
  output logic       id_keep,
  output logic       id_nop,
  output logic       if_flush,
  output logic       ex_keep,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic [1:0] busy_state
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    MEMWAIT = 2'b11
  } state_t;

  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  state_t     saved_state, saved_nxt;  // state to resume after a memory wait
  logic [2:0] cnt, cnt_nxt;
  logic       lu, mw;
  logic       do_stall, do_flush, do_mem;

  assign lu = id_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) |
               (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mw = dmem_req & ~dmem_ack;

  always_comb begin
    do_stall  = 1'b0;
    do_flush  = 1'b0;
    do_mem    = 1'b0;
    state_nxt = state;
    saved_nxt = saved_state;
    cnt_nxt   = cnt;
    if (mw) begin
      // Freeze everything; the counter and the interrupted state are kept.
      do_mem    = 1'b1;
      state_nxt = MEMWAIT;
      if (state != MEMWAIT) saved_nxt = state;
    end else if (br_taken) begin
      do_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    end else begin
      case (state)
        LDSTALL: begin
          do_stall  = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          state_nxt = (cnt <= 3'd1) ? RUN : LDSTALL;
        end
        FLUSH: begin
          do_flush  = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          state_nxt = (cnt <= 3'd1) ? RUN : FLUSH;
        end
        default: begin
          // RUN, or the ack cycle leaving MEMWAIT (evaluated as RUN).
          if (lu) begin
            do_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LDSTALL;
              cnt_nxt   = LOAD_RELOAD;
            end else begin
              state_nxt = RUN;
              cnt_nxt   = 3'd0;
            end
          end else if (state == MEMWAIT) begin
            // No new event: pick up where the wait interrupted us.
            state_nxt = saved_state;
          end else begin
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= 3'd0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      cnt         <= cnt_nxt;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs)    return 2'b10;
    return 2'b00;
  endfunction

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign pc_keep    = rst & (do_stall | do_mem);
  assign if_keep    = rst & (do_stall | do_mem);
  assign id_keep    = rst & do_mem;
  assign ex_keep    = rst & do_mem;
  assign id_nop     = rst & (do_stall | do_flush) & ~do_mem;
  assign if_flush   = rst & do_flush;
  assign fwd_rs1    = rst ? fwd_sel(id_rs1) : 2'b00;
  assign fwd_rs2    = rst ? fwd_sel(id_rs2) : 2'b00;
  assign busy_state = state;

`ifdef HAZARD_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt   <= 32'd0;
      perf_flush_cnt   <= 32'd0;
      perf_memwait_cnt <= 32'd0;
    end else if (perf_clr) begin
      perf_stall_cnt   <= 32'd0;
      perf_flush_cnt   <= 32'd0;
      perf_memwait_cnt <= 32'd0;
    end else begin
      if (pc_keep && !ex_keep && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (if_flush && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (ex_keep && perf_memwait_cnt != 32'hFFFF_FFFF)
        perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched. Two instances share one stimulus:
//   u_a : LOAD_LAT=1, FLUSH_CYCLES=2
//   u_b : LOAD_LAT=3, FLUSH_CYCLES=2
// Each cycle the expected output vector of both instances is pushed to a
// queue when stimulus is driven and popped when the outputs are sampled.
// Vector layout: {pc_keep,if_keep,id_keep,id_nop,if_flush,ex_keep,
//                 fwd_rs1,fwd_rs2,busy_state}
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic       br_taken, dmem_req, dmem_ack;

  logic       a_pk, a_ik, a_dk, a_nop, a_fl, a_ek;
  logic [1:0] a_f1, a_f2, a_bs;
  logic       b_pk, b_ik, b_dk, b_nop, b_fl, b_ek;
  logic [1:0] b_f1, b_f2, b_bs;
`ifdef HAZARD_SCHED_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] a_ps, a_pf, a_pm, b_ps, b_pf, b_pm;
`endif

  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hazard_sched #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
`ifdef HAZARD_SCHED_PERF_EN
    .perf_clr(perf_clr), .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf),
    .perf_memwait_cnt(a_pm),
`endif
    .pc_keep(a_pk), .if_keep(a_ik), .id_keep(a_dk), .id_nop(a_nop),
    .if_flush(a_fl), .ex_keep(a_ek), .fwd_rs1(a_f1), .fwd_rs2(a_f2),
    .busy_state(a_bs)
  );

  hazard_sched #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
`ifdef HAZARD_SCHED_PERF_EN
    .perf_clr(perf_clr), .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf),
    .perf_memwait_cnt(b_pm),
`endif
    .pc_keep(b_pk), .if_keep(b_ik), .id_keep(b_dk), .id_nop(b_nop),
    .if_flush(b_fl), .ex_keep(b_ek), .fwd_rs1(b_f1), .fwd_rs2(b_f2),
    .busy_state(b_bs)
  );

  wire [11:0] obs_a = {a_pk, a_ik, a_dk, a_nop, a_fl, a_ek, a_f1, a_f2, a_bs};
  wire [11:0] obs_b = {b_pk, b_ik, b_dk, b_nop, b_fl, b_ek, b_f1, b_f2, b_bs};

  // Common expected patterns (fwd fields filled in by ev()).
  function automatic logic [11:0] ev(input logic pk, ik, dk, nop, fl, ek,
                                     input logic [1:0] f1, f2, bs);
    return {pk, ik, dk, nop, fl, ek, f1, f2, bs};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %03h expected %03h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_inputs();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
    br_taken = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic drive_lu();
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5;
  endtask

  // Called just after a negedge with inputs set: queue expectations, sample
  // 1 time unit later, then advance to the next negedge.
  task automatic step(input string tag, input logic [11:0] ea,
                      input logic [11:0] eb);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    #1;
    check({tag, "/a"}, obs_a, exp_a_q.pop_front());
    check({tag, "/b"}, obs_b, exp_b_q.pop_front());
    @(negedge clk);
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs,
                                           input logic mw, input logic [4:0] md,
                                           input logic ww, input logic [4:0] wd);
    if (mw && md != 0 && md == rs) return 2'b01;
    if (ww && wd != 0 && wd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] z, stl, fl, mwv;
    z   = ev(0,0,0,0,0,0,2'b00,2'b00,2'b00);
    fl  = ev(0,0,0,1,1,0,2'b00,2'b00,2'b00);
    mwv = ev(1,1,1,0,0,1,2'b00,2'b00,2'b00);

    // Reset held with a branch pending: outputs must stay 0.
    clear_inputs();
    br_taken = 1;
    step("reset", z, z);
    clear_inputs();
    rst = 1'b1;
    step("post_reset", z, z);

    // x0 never creates a load-use hazard.
    drive_lu(); id_rs1 = 0; ex_rd = 0;
    step("lu_x0", z, z);

    // Load-use: A stalls 1 cycle, B stalls 3.
    clear_inputs(); drive_lu();
    stl = ev(1,1,0,1,0,0,2'b00,2'b00,2'b00);
    step("lu_c0", stl, stl);
    clear_inputs(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5;
    mem_regwrite = 1; mem_rd = 5'd5;
    step("lu_c1", ev(0,0,0,0,0,0,2'b01,2'b00,2'b00),
                  ev(1,1,0,1,0,0,2'b01,2'b00,2'b01));
    mem_regwrite = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 5'd5;
    step("lu_c2", ev(0,0,0,0,0,0,2'b10,2'b00,2'b00),
                  ev(1,1,0,1,0,0,2'b10,2'b00,2'b01));
    clear_inputs();
    step("lu_done", z, z);

    // Taken branch, FLUSH_CYCLES=2.
    br_taken = 1;
    step("br_c0", fl, fl);
    br_taken = 0;
    step("br_c1", ev(0,0,0,1,1,0,2'b00,2'b00,2'b10),
                  ev(0,0,0,1,1,0,2'b00,2'b00,2'b10));
    step("br_done", z, z);

    // Memory wait with branch and load-use pending throughout.
    drive_lu(); br_taken = 1; dmem_req = 1; dmem_ack = 0;
    step("mw_c0", mwv, mwv);
    for (int i = 1; i < 4; i++)
      step("mw_cn", ev(1,1,1,0,0,1,2'b00,2'b00,2'b11),
                    ev(1,1,1,0,0,1,2'b00,2'b00,2'b11));
    dmem_ack = 1;
    step("mw_ack", ev(0,0,0,1,1,0,2'b00,2'b00,2'b11),
                   ev(0,0,0,1,1,0,2'b00,2'b00,2'b11));
    clear_inputs();
    step("mw_flush", ev(0,0,0,1,1,0,2'b00,2'b00,2'b10),
                     ev(0,0,0,1,1,0,2'b00,2'b00,2'b10));
    step("mw_done", z, z);

    // Forwarding priority and x0.
    mem_regwrite = 1; mem_rd = 5'd7; wb_regwrite = 1; wb_rd = 5'd7; id_rs2 = 5'd7;
    step("fwd_mem_wins", ev(0,0,0,0,0,0,2'b00,2'b01,2'b00),
                         ev(0,0,0,0,0,0,2'b00,2'b01,2'b00));
    mem_rd = 0; wb_rd = 0; id_rs2 = 0;
    step("fwd_x0", z, z);
    mem_regwrite = 0; wb_regwrite = 1; wb_rd = 5'd9; id_rs1 = 5'd9;
    step("fwd_wb", ev(0,0,0,0,0,0,2'b10,2'b00,2'b00),
                   ev(0,0,0,0,0,0,2'b10,2'b00,2'b00));

    // Random forwarding patterns on small register ranges.
    for (int i = 0; i < 20; i++) begin
      logic [11:0] e;
      clear_inputs();
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      e = ev(0,0,0,0,0,0,
             fwd_model(id_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd),
             fwd_model(id_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd),
             2'b00);
      step("fwd_rand", e, e);
    end

    // Reset asserted while in FLUSH with counter 1.
    clear_inputs(); br_taken = 1;
    step("rf_br", fl, fl);
    br_taken = 0; rst = 1'b0;
    step("rf_reset", z, z);
    rst = 1'b1;
    step("rf_release", z, z);
    step("rf_idle", z, z);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
